serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, which sets the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 SHALL have ports a and b, inputs, WIDTH bits each: the minuend and the subtrahend.
REQ-007 SHALL have port diff, output, WIDTH bits: the result a - b, modulo 2^WIDTH.
REQ-008 SHALL have port borrow, output, 1 bit: 1 when a < b, compared unsigned.
REQ-009 SHALL have port out_valid, output, 1 bit: diff and borrow are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-011 SHALL implement a 3-state FSM with states IDLE, SHIFT and DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-013 SHALL, in IDLE on in_valid&&in_ready, capture a and b, clear the running borrow and bit counter, and go to SHIFT.
REQ-014 SHALL, in SHIFT, process one bit per cycle LSB-first:
- d = a_i XOR b_i XOR br
- br' = (~a_i & b_i) | (~(a_i XOR b_i) & br)
- shift d into diff from the MSB side.
REQ-015 SHALL go from SHIFT to DONE after exactly WIDTH SHIFT cycles, so out_valid rises WIDTH+1 edges after the accepting edge.
REQ-016 SHALL set borrow to the final running borrow when entering DONE.
REQ-017 SHALL, in DONE, hold diff and borrow stable until out_valid&&out_ready, then return to IDLE on the next edge.
REQ-018 SHALL NOT accept new operands in the same cycle a result is consumed; in_ready rises the cycle after the result handoff.
REQ-019 SHALL ignore changes on a and b and in_valid while in SHIFT or DONE.
REQ-020 SHALL wrap diff modulo 2^WIDTH, so a=0, b=1 gives all-ones diff with borrow=1.

Reset
REQ-021 SHALL, when rst_n=0 at a clock edge, force:
- state to IDLE
- diff=0, borrow=0, out_valid=0
- the bit counter and internal operand registers to 0.
REQ-022 SHALL treat reset asserted mid-SHIFT or mid-DONE as aborting the operation: no out_valid pulse follows, and in_ready=1 on the first cycle after reset is released.

Configuration
REQ-023 SHALL, when macro SERIAL_SUBTRACTOR_OVF_EN is defined, add output port ovf (1 bit): signed two's-complement overflow, defined as (a_msb != b_msb) && (diff_msb != a_msb), valid with out_valid and reset to 0.
REQ-024 SHALL, when SERIAL_SUBTRACTOR_OVF_EN is undefined, have no ovf port and no overflow logic.

Structure
REQ-025 SHALL take its FSM state enum (IDLE/SHIFT/DONE) and the default-width constant from a shared package, serial_sub_pkg.
REQ-026 SHALL instantiate a single combinational one-bit cell, full_subtractor (inputs a, b, bin; outputs d, bout), for the per-bit datapath.

Verification
REQ-027 SHALL cover, with WIDTH=4: a=9, b=3 -> diff=6, borrow=0, out_valid 5 edges after acceptance.
REQ-028 SHALL cover: a=3, b=9 -> diff=4'hA, borrow=1; and a=0, b=1 -> diff=4'hF, borrow=1.
REQ-029 SHALL cover: a=15, b=15 and a=0, b=0 -> diff=0, borrow=0.
REQ-030 SHALL cover backpressure: out_ready held 0 for 10 cycles -> diff, borrow and out_valid stable, in_ready=0 throughout, then one handoff followed by in_ready=1.
REQ-031 SHALL cover reset on the 2nd SHIFT cycle -> all outputs 0, in_ready=1 after release, and no spurious out_valid.
REQ-032 SHALL cover, with SERIAL_SUBTRACTOR_OVF_EN defined: a=8, b=1 -> diff=7, ovf=1; and a=5, b=3 -> diff=2, ovf=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
// Latency: combinational.
// Backpressure: none.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per cycle; SERIAL_SUBTRACTOR_OVF_EN adds signed overflow output ovf.
// Latency: out_valid rises WIDTH edges after the accepting edge (WIDTH+1 counting that edge).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, one cycle after handoff.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             out_valid,
    input  logic             out_ready
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic               borrow_q, borrow_d;

    logic accept;
    logic last_bit;
    logic fs_d;
    logic fs_bout;

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)                 state_d = SHIFT;
            SHIFT:   if (last_bit)               state_d = DONE;
            DONE:    if (out_valid && out_ready) state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Operands shift right so the current bit is always at index 0;
    // result bits enter at the MSB and settle into place after WIDTH shifts.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d      = a;
                    b_d      = b;
                    diff_d   = '0;
                    cnt_d    = '0;
                    br_d     = 1'b0;
                    borrow_d = 1'b0;
                end
            end
            SHIFT: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                diff_d = {fs_d, diff_q[WIDTH-1:1]};
                br_d   = fs_bout;
                cnt_d  = cnt_q + 1'b1;
                if (last_bit) borrow_d = fs_bout;
            end
            default: ;
        endcase
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    // Sign bits are kept aside because the operand registers shift them away.
    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && accept) begin
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
            ovf_d   = 1'b0;
        end else if (state_q == SHIFT && last_bit) begin
            ovf_d = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
